// File: rtl/shifter_stage_pkg.sv
// Shared types for the ARM operand-2 shifter stage: shift-type codes,
// FSM state encoding and the prepared-field bundle held between cycles.
package shifter_pkg;

  localparam int SHIFT_W = 32;

  localparam logic [1:0] SH_LSL = 2'b00;
  localparam logic [1:0] SH_LSR = 2'b01;
  localparam logic [1:0] SH_ASR = 2'b10;
  localparam logic [1:0] SH_ROR = 2'b11;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    REGSH = 1'b1
  } state_e;

  // Barrel-shifter inputs already normalised from the instruction fields,
  // plus the pass-through operands that travel alongside them.
  typedef struct packed {
    logic [3:0]         opcode;
    logic [SHIFT_W-1:0] a;
    logic [SHIFT_W-1:0] rm;
    logic [7:0]         amount;
    logic [1:0]         sh_type;
    logic               c;
    logic               reg_form;
  } shift_fields_t;

endpackage

// File: rtl/shifter_stage_if.sv
// Decoded-field input and ALU-side output bundle of the shifter stage.
// master drives instruction fields and out_ready; slave is the stage.
interface shifter_stage_if;
  import shifter_pkg::*;

  logic               in_valid;
  logic               in_ready;
  logic [3:0]         in_opcode;
  logic [SHIFT_W-1:0] in_a;
  logic [SHIFT_W-1:0] in_rm;
  logic [7:0]         in_rs;
  logic               in_imm_form;
  logic [7:0]         in_imm8;
  logic [3:0]         in_rot;
  logic [1:0]         in_shift_type;
  logic [4:0]         in_shift_imm;
  logic               in_reg_shift;
  logic               in_c;
  logic               out_valid;
  logic               out_ready;
  logic [3:0]         out_opcode;
  logic [SHIFT_W-1:0] out_a;
  logic [SHIFT_W-1:0] out_b;
  logic               out_shifter_carry;

  modport master (
    output in_valid, in_opcode, in_a, in_rm, in_rs, in_imm_form, in_imm8,
           in_rot, in_shift_type, in_shift_imm, in_reg_shift, in_c, out_ready,
    input  in_ready, out_valid, out_opcode, out_a, out_b, out_shifter_carry
  );

  modport slave (
    input  in_valid, in_opcode, in_a, in_rm, in_rs, in_imm_form, in_imm8,
           in_rot, in_shift_type, in_shift_imm, in_reg_shift, in_c, out_ready,
    output in_ready, out_valid, out_opcode, out_a, out_b, out_shifter_carry
  );

endinterface

// File: rtl/shifter_stage_barrel_shift.sv
// Combinational ARM barrel shifter: (rm, amount, type, c, reg_form) -> (b, carry).
// reg_form=0 applies the immediate-shift encodings where an amount of 0 is special.
module barrel_shift
  import shifter_pkg::*;
(
  input  logic [SHIFT_W-1:0] rm,
  input  logic [7:0]         amount,
  input  logic [1:0]         sh_type,
  input  logic               c,
  input  logic               reg_form,
  output logic [SHIFT_W-1:0] b,
  output logic               carry
);

  logic [4:0]  sh5_s;
  logic [32:0] lsl_s;
  logic [32:0] lsr_s;
  logic [32:0] asr_s;
  logic [63:0] ror_s;
  logic        amount_zero_s;
  logic        big_s;
  logic        eq32_s;

  // The extra bit in each wide vector catches the last bit shifted out.
  assign sh5_s  = amount[4:0];
  assign lsl_s  = {1'b0, rm} << sh5_s;
  assign lsr_s  = {rm, 1'b0} >> sh5_s;
  assign asr_s  = $signed({rm, 1'b0}) >>> sh5_s;
  assign ror_s  = {rm, rm} >> sh5_s;
  assign eq32_s = (amount == 8'd32);
  assign big_s  = reg_form && (amount[7:5] != 3'd0);
  assign amount_zero_s = reg_form ? (amount == 8'd0) : (sh5_s == 5'd0);

  // Select result and carry-out for the zero, >=32 and ordinary cases.
  always_comb begin
    b     = rm;
    carry = c;
    if (amount_zero_s) begin
      if (reg_form) begin
        b     = rm;
        carry = c;
      end else begin
        case (sh_type)
          SH_LSL: begin b = rm;             carry = c;      end
          SH_LSR: begin b = 32'h0000_0000;  carry = rm[31]; end
          SH_ASR: begin b = {32{rm[31]}};   carry = rm[31]; end
          SH_ROR: begin b = {c, rm[31:1]};  carry = rm[0];  end
          default: begin b = rm;            carry = c;      end
        endcase
      end
    end else if (big_s) begin
      case (sh_type)
        SH_LSL: begin b = 32'h0000_0000; carry = eq32_s ? rm[0] : 1'b0;  end
        SH_LSR: begin b = 32'h0000_0000; carry = eq32_s ? rm[31] : 1'b0; end
        SH_ASR: begin b = {32{rm[31]}};  carry = rm[31];                 end
        SH_ROR: begin b = ror_s[31:0];   carry = ror_s[31];              end
        default: begin b = rm;           carry = c;                      end
      endcase
    end else begin
      case (sh_type)
        SH_LSL: begin b = lsl_s[31:0]; carry = lsl_s[32]; end
        SH_LSR: begin b = lsr_s[32:1]; carry = lsr_s[0];  end
        SH_ASR: begin b = asr_s[32:1]; carry = asr_s[0];  end
        SH_ROR: begin b = ror_s[31:0]; carry = ror_s[31]; end
        default: begin b = rm;         carry = c;         end
      endcase
    end
  end

endmodule

// File: rtl/shifter_stage.sv
// Registered ARM operand-2 stage feeding the ALU over valid/ready.
// SHIFTER_REGSHIFT_2CYC_EN adds the REGSH cycle for register-specified shifts.
module shifter_stage
  import shifter_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  shifter_stage_if.slave  bus
);

  state_e             state_r;
  state_e             state_n_s;
  shift_fields_t      hold_r;
  shift_fields_t      in_fields_s;
  shift_fields_t      sel_fields_s;
  logic               in_ready_s;
  logic               accept_s;
  logic               load_s;
  logic               hold_load_s;
  logic [SHIFT_W-1:0] b_s;
  logic               carry_s;
  logic               out_valid_r;
  logic [3:0]         out_opcode_r;
  logic [SHIFT_W-1:0] out_a_r;
  logic [SHIFT_W-1:0] out_b_r;
  logic               out_carry_r;

  assign in_ready_s = (state_r == RUN) && !flush && (!out_valid_r || bus.out_ready);
  assign accept_s   = bus.in_valid && in_ready_s;

  // The rotated immediate is a register-form ROR by 2*rot: an amount of 0 keeps C.
  always_comb begin
    in_fields_s.opcode = bus.in_opcode;
    in_fields_s.a      = bus.in_a;
    in_fields_s.c      = bus.in_c;
    if (bus.in_imm_form) begin
      in_fields_s.rm       = {24'h00_0000, bus.in_imm8};
      in_fields_s.amount   = {3'b000, bus.in_rot, 1'b0};
      in_fields_s.sh_type  = SH_ROR;
      in_fields_s.reg_form = 1'b1;
    end else begin
      in_fields_s.rm       = bus.in_rm;
      in_fields_s.amount   = bus.in_reg_shift ? bus.in_rs : {3'b000, bus.in_shift_imm};
      in_fields_s.sh_type  = bus.in_shift_type;
      in_fields_s.reg_form = bus.in_reg_shift;
    end
  end

  assign sel_fields_s = (state_r == REGSH) ? hold_r : in_fields_s;

  barrel_shift u_barrel_shift (
    .rm       (sel_fields_s.rm),
    .amount   (sel_fields_s.amount),
    .sh_type  (sel_fields_s.sh_type),
    .c        (sel_fields_s.c),
    .reg_form (sel_fields_s.reg_form),
    .b        (b_s),
    .carry    (carry_s)
  );

  // Next-state and load decisions; flush overrides everything.
  always_comb begin
    state_n_s   = state_r;
    load_s      = 1'b0;
    hold_load_s = 1'b0;
    if (flush) begin
      state_n_s = RUN;
    end else begin
      case (state_r)
        RUN: begin
          if (accept_s) begin
`ifdef SHIFTER_REGSHIFT_2CYC_EN
            if (bus.in_reg_shift && !bus.in_imm_form) begin
              hold_load_s = 1'b1;
              state_n_s   = REGSH;
            end else begin
              load_s = 1'b1;
            end
`else
            load_s = 1'b1;
`endif
          end else begin
            state_n_s = RUN;
          end
        end
        REGSH: begin
          load_s    = 1'b1;
          state_n_s = RUN;
        end
        default: begin
          state_n_s = RUN;
        end
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= RUN;
    end else begin
      state_r <= state_n_s;
    end
  end

  // Hold register for the deferred register-shift computation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_r <= '0;
    end else if (flush) begin
      hold_r <= '0;
    end else if (hold_load_s) begin
      hold_r <= in_fields_s;
    end else begin
      hold_r <= hold_r;
    end
  end

  // Output register: data only changes on a load, so it holds under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r  <= 1'b0;
      out_opcode_r <= 4'h0;
      out_a_r      <= 32'h0000_0000;
      out_b_r      <= 32'h0000_0000;
      out_carry_r  <= 1'b0;
    end else if (flush) begin
      out_valid_r <= 1'b0;
    end else if (load_s) begin
      out_valid_r  <= 1'b1;
      out_opcode_r <= sel_fields_s.opcode;
      out_a_r      <= sel_fields_s.a;
      out_b_r      <= b_s;
      out_carry_r  <= carry_s;
    end else if (out_valid_r && bus.out_ready) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  assign bus.in_ready          = in_ready_s;
  assign bus.out_valid         = out_valid_r;
  assign bus.out_opcode        = out_opcode_r;
  assign bus.out_a             = out_a_r;
  assign bus.out_b             = out_b_r;
  assign bus.out_shifter_carry = out_carry_r;

endmodule
